// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared widths, FSM state encoding and request record for the MEM sequencer
package mem_pkg;

    localparam int MEM_ADDR_W = 3;
    localparam int MEM_DATA_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_RD_WAIT,
        ST_RSP
    } state_t;

    typedef struct packed {
        logic                  write;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/mem_req_fifo.sv
// rtl/mem_req_fifo.sv - synchronous request FIFO with registered full/empty flags
module mem_req_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int WIDTH      = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

    logic [WIDTH-1:0] store [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_next;
    logic             do_push;
    logic             do_pop;

    // Gating here makes push/pop safe to drive from raw valid/request signals.
    assign do_push    = push && !full;
    assign do_pop     = pop && !empty;
    assign count_next = count + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
    assign pop_data   = store[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_next;
            full  <= (count_next == FULL_CNT);
            empty <= (count_next == '0);
        end
    end

endmodule

// File: rtl/mem_req_ctrl.sv
// rtl/mem_req_ctrl.sv - sequences queued read/write requests into single-cycle MEM control pulses
module mem_req_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W     = MEM_ADDR_W,
    parameter int DATA_W     = MEM_DATA_W,
    parameter int FIFO_DEPTH = 4,
    parameter int READ_LAT   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              mem_read_ctrl,
    output logic              mem_write_ctrl,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_write,
    input  logic [DATA_W-1:0] mem_data_read,
    output logic              busy
);

    localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(READ_LAT - 1);

    state_t           state;
    state_t           state_next;
    req_t             push_req;
    req_t             head;
    logic             full;
    logic             empty;
    logic             pop;
    logic             try_issue;
    logic             capture;
    logic             rsp_clear;
    logic [CNT_W-1:0] wait_cnt;

    assign push_req  = {req_write, req_addr, req_wdata};
    assign req_ready = !full;
    assign busy      = !empty || (state != ST_IDLE);

    mem_req_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      ($bits(req_t))
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (req_valid),
        .push_data (push_req),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty)
    );

    always_comb begin
        state_next = state;
        try_issue  = 1'b0;
        capture    = 1'b0;
        rsp_clear  = 1'b0;
        pop        = 1'b0;
        unique case (state)
            ST_IDLE:    try_issue = 1'b1;
            ST_WR:      try_issue = 1'b1;
            ST_RD:      state_next = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (wait_cnt == '0) begin
                    capture    = 1'b1;
                    state_next = ST_RSP;
                end
            end
            ST_RSP: begin
                // Nothing is issued until the held response is taken.
                if (rsp_ready) begin
                    rsp_clear = 1'b1;
                    try_issue = 1'b1;
                end
            end
            default:    state_next = ST_IDLE;
        endcase
        if (try_issue) begin
            if (!empty) begin
                pop        = 1'b1;
                state_next = head.write ? ST_WR : ST_RD;
            end else begin
                state_next = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            wait_cnt       <= '0;
            mem_read_ctrl  <= 1'b0;
            mem_write_ctrl <= 1'b0;
            mem_address    <= '0;
            mem_data_write <= '0;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
            rsp_addr       <= '0;
        end else begin
            state          <= state_next;
            mem_write_ctrl <= pop && head.write;
            mem_read_ctrl  <= pop && !head.write;
            mem_data_write <= (pop && head.write) ? head.wdata : '0;
            if (pop) begin
                mem_address <= head.addr;
            end
            if (state == ST_RD) begin
                wait_cnt <= WAIT_LOAD;
            end else if (state == ST_RD_WAIT && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - CNT_W'(1);
            end
            if (capture) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= mem_data_read;
                rsp_addr  <= mem_address;
            end else if (rsp_clear) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb/tb_mem_req_ctrl.sv - directed self-checking bench for mem_req_ctrl with a behavioural 8x3 MEM
module tb_mem_req_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [2:0] req_addr;
    logic [2:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [2:0] rsp_rdata;
    logic [2:0] rsp_addr;
    logic       mem_read_ctrl;
    logic       mem_write_ctrl;
    logic [2:0] mem_address;
    logic [2:0] mem_data_write;
    logic [2:0] mem_data_read = 3'b000;
    logic       busy;

    logic [2:0] mem_model [8] = '{default: 3'b000};
    int n_assert = 0;
    int n_fail = 0;
    int wr_pulses = 0;
    int rd_pulses = 0;
    int both_pulses = 0;
    int wr_snap;
    int rd_snap;
    logic saw_valid;

    always #5 clk = ~clk;

    mem_req_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_rdata      (rsp_rdata),
        .rsp_addr       (rsp_addr),
        .mem_read_ctrl  (mem_read_ctrl),
        .mem_write_ctrl (mem_write_ctrl),
        .mem_address    (mem_address),
        .mem_data_write (mem_data_write),
        .mem_data_read  (mem_data_read),
        .busy           (busy)
    );

    always @(posedge clk) begin
        if (mem_write_ctrl) mem_model[mem_address] <= mem_data_write;
        if (mem_read_ctrl) mem_data_read <= mem_model[mem_address];
    end

    always @(negedge clk) begin
        if (mem_write_ctrl === 1'b1) wr_pulses <= wr_pulses + 1;
        if (mem_read_ctrl === 1'b1) rd_pulses <= rd_pulses + 1;
        if (mem_write_ctrl === 1'b1 && mem_read_ctrl === 1'b1) both_pulses <= both_pulses + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic w, input logic [2:0] a, input logic [2:0] d);
        int n = 0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        check("push_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input logic [2:0] d, input logic [2:0] a);
        int n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, rsp_valid, 1);
        check({tag, "_rdata"}, rsp_rdata, d);
        check({tag, "_addr"}, rsp_addr, a);
        tick();
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 3'd0;
        req_wdata = 3'd0; rsp_ready = 1'b0;

        // Reset then idle
        tick(); tick();
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_addr", rsp_addr, 0);
        check("rst_mem_rd", mem_read_ctrl, 0);
        check("rst_mem_wr", mem_write_ctrl, 0);
        check("rst_mem_addr", mem_address, 0);
        check("rst_mem_wdata", mem_data_write, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        wr_snap = wr_pulses; rd_snap = rd_pulses;
        repeat (10) tick();
        check("idle_wr_pulses", wr_pulses - wr_snap, 0);
        check("idle_rd_pulses", rd_pulses - rd_snap, 0);
        check("idle_busy", busy, 0);

        // Write then readback
        rsp_ready = 1'b1;
        wr_snap = wr_pulses; rd_snap = rd_pulses;
        push(1'b1, 3'd0, 3'b010);
        push(1'b1, 3'd1, 3'b101);
        push(1'b0, 3'd0, 3'd0);
        push(1'b0, 3'd1, 3'd0);
        wait_rsp("rb0", 3'b010, 3'd0);
        wait_rsp("rb1", 3'b101, 3'd1);
        check("rb_wr_pulses", wr_pulses - wr_snap, 2);
        check("rb_rd_pulses", rd_pulses - rd_snap, 2);

        // Backpressure with a write queued behind the held response
        rsp_ready = 1'b0;
        push(1'b0, 3'd1, 3'd0);
        push(1'b1, 3'd6, 3'b011);
        wait_rsp("bp", 3'b101, 3'd1);
        wr_snap = wr_pulses; rd_snap = rd_pulses;
        saw_valid = 1'b1;
        repeat (5) begin
            tick();
            saw_valid = saw_valid & rsp_valid & (rsp_rdata == 3'b101);
        end
        check("bp_held", saw_valid, 1);
        check("bp_no_wr", wr_pulses - wr_snap, 0);
        check("bp_no_rd", rd_pulses - rd_snap, 0);
        rsp_ready = 1'b1;
        tick();
        check("bp_rsp_cleared", rsp_valid, 0);
        check("bp_wr_pulse", mem_write_ctrl, 1);
        check("bp_wr_addr", mem_address, 6);
        check("bp_wr_data", mem_data_write, 3'b011);
        tick();
        check("bp_wr_done", mem_write_ctrl, 0);
        check("bp_wdata_zero", mem_data_write, 0);
        check("bp_addr_hold", mem_address, 6);
        check("bp_idle", busy, 0);

        // FIFO full
        rsp_ready = 1'b0;
        wr_snap = wr_pulses; rd_snap = rd_pulses;
        push(1'b0, 3'd0, 3'd0);
        push(1'b0, 3'd1, 3'd0);
        push(1'b1, 3'd7, 3'b111);
        push(1'b0, 3'd7, 3'd0);
        push(1'b0, 3'd0, 3'd0);
        check("full_ready_low", req_ready, 0);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 3'd5; req_wdata = 3'b110;
        saw_valid = 1'b0;
        repeat (3) begin
            tick();
            saw_valid = saw_valid | req_ready;
        end
        req_valid = 1'b0;
        check("full_stays_low", saw_valid, 0);
        rsp_ready = 1'b1;
        wait_rsp("full0", 3'b010, 3'd0);
        wait_rsp("full1", 3'b101, 3'd1);
        wait_rsp("full2", 3'b111, 3'd7);
        wait_rsp("full3", 3'b010, 3'd0);
        tick();
        check("full_ready_back", req_ready, 1);
        check("full_drained", busy, 0);
        check("full_wr_pulses", wr_pulses - wr_snap, 1);
        check("full_rd_pulses", rd_pulses - rd_snap, 4);

        // Reset mid-read
        push(1'b0, 3'd0, 3'd0);
        tick();
        check("mr_rd_pulse", mem_read_ctrl, 1);
        check("mr_rd_addr", mem_address, 0);
        tick();
        check("mr_in_wait", mem_read_ctrl, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mr_rsp_valid", rsp_valid, 0);
        check("mr_busy", busy, 0);
        check("mr_req_ready", req_ready, 1);
        check("mr_no_pulse", mem_read_ctrl | mem_write_ctrl, 0);
        saw_valid = 1'b0;
        repeat (5) begin
            tick();
            saw_valid = saw_valid | rsp_valid;
        end
        check("mr_never_valid", saw_valid, 0);
        push(1'b0, 3'd0, 3'd0);
        tick();
        check("lat_n1", rsp_valid, 0);
        tick();
        check("lat_n2", rsp_valid, 0);
        tick();
        check("lat_n3", rsp_valid, 1);
        check("lat_rdata", rsp_rdata, 3'b010);
        check("lat_addr", rsp_addr, 0);
        tick();

        // Back-to-back writes
        wr_snap = wr_pulses; rd_snap = rd_pulses;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 3'd0; req_wdata = 3'b001;
        tick();
        check("b2b_not_yet", mem_write_ctrl, 0);
        for (int i = 1; i <= 4; i++) begin
            req_addr  = 3'(i);
            req_wdata = 3'(i + 1);
            if (i == 4) req_valid = 1'b0;
            check("b2b_ready", req_ready, 1);
            tick();
            check("b2b_wr", mem_write_ctrl, 1);
            check("b2b_rd", mem_read_ctrl, 0);
            check("b2b_addr", mem_address, i - 1);
            check("b2b_data", mem_data_write, i);
        end
        tick();
        check("b2b_end_wr", mem_write_ctrl, 0);
        check("b2b_end_addr", mem_address, 3);
        check("b2b_wr_pulses", wr_pulses - wr_snap, 4);
        check("b2b_rd_pulses", rd_pulses - rd_snap, 0);

        push(1'b0, 3'd3, 3'd0);
        wait_rsp("rd3", 3'b100, 3'd3);
        push(1'b0, 3'd5, 3'd0);
        wait_rsp("rd5", 3'b000, 3'd5);
        check("rd_wr_exclusive", both_pulses, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
